// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D main-memory arbiter.
// FSM states and grant identifiers.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker for the memory arbiter.
// On a tie the side opposite last_grant wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   valid
);

  // Pick a requester; ties rotate away from the last winner
  always_comb begin
    grant = GRANT_I;
    valid = req_i | req_d;
    unique case (1'b1)
      (req_i & req_d):
        grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
      (req_d & ~req_i):
        grant = GRANT_D;
      default:
        grant = GRANT_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between I-cache and D-cache.
// Serialises transactions, round-robin on ties, watchdog on hangs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t    state;
  arb_state_t    state_n;
  grant_t        last_grant;
  grant_t        pick;
  logic          pick_valid;
  logic          grant;
  logic          op_we;
  logic          we_n;
  logic          in_busy;
  logic          expire;
  logic [CW-1:0] wd_cnt;

  rr_pick2 u_pick (
    .req_i      (ic_req),
    .req_d      (dc_req),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  assign grant   = (state == IDLE) && pick_valid;
  assign in_busy = (state == BUSY_I) || (state == BUSY_D);
  assign expire  = (wd_cnt == CW'(TIMEOUT - 1));
  assign we_n    = grant ? dc_we : op_we;

  // Next-state: grant from IDLE, finish on ready or watchdog
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (pick_valid)
          state_n = (pick == GRANT_D) ? BUSY_D : BUSY_I;
      BUSY_I:
        if (mem_ready || expire) state_n = RESP_I;
      BUSY_D:
        if (mem_ready || expire) state_n = RESP_D;
      RESP_I,
      RESP_D:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // State, registered strobes and grant history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      ic_ready   <= 1'b0;
      dc_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state    <= state_n;
      mem_req  <= (state_n == BUSY_I) || (state_n == BUSY_D);
      mem_we   <= (state_n == BUSY_D) && we_n;
      ic_ready <= (state_n == RESP_I);
      dc_ready <= (state_n == RESP_D);
      busy     <= (state_n != IDLE);
      if (grant) last_grant <= pick;
    end
  end

  // Latch the granted transaction onto the memory port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      op_we     <= 1'b0;
    end else if (grant) begin
      if (pick == GRANT_D) begin
        mem_addr  <= dc_addr;
        mem_wdata <= dc_wdata;
        op_we     <= dc_we;
      end else begin
        mem_addr  <= ic_addr;
        mem_wdata <= '0;
        op_we     <= 1'b0;
      end
    end
  end

  // Watchdog counts BUSY cycles; sticky error on expiry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant)
        wd_cnt <= '0;
      else if (in_busy)
        wd_cnt <= wd_cnt + CW'(1);
      if (in_busy && !mem_ready && expire)
        timeout_err <= 1'b1;
    end
  end

  // Capture returned lines on completed reads only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ic_rdata <= '0;
      dc_rdata <= '0;
    end else begin
      if (state == BUSY_I && mem_ready)
        ic_rdata <= mem_rdata;
      if (state == BUSY_D && mem_ready && !op_we)
        dc_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Cycle vectors plus directed multi-cycle sequences.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clock;
  logic          reset;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_ready;
  logic [LW-1:0] ic_rdata;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          dc_ready;
  logic [LW-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ready;
  logic [LW-1:0] mem_rdata;
  logic          busy;
  logic          timeout_err;

  mem_arbiter #(
    .ADDR_W  (AW),
    .LINE_W  (LW),
    .TIMEOUT (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ic_req      (ic_req),
    .ic_addr     (ic_addr),
    .ic_ready    (ic_ready),
    .ic_rdata    (ic_rdata),
    .dc_req      (dc_req),
    .dc_we       (dc_we),
    .dc_addr     (dc_addr),
    .dc_wdata    (dc_wdata),
    .dc_ready    (dc_ready),
    .dc_rdata    (dc_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [LW-1:0] Z  = '0;
  localparam logic [LW-1:0] L1 =
    128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [LW-1:0] L2 =
    128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [LW-1:0] L3 =
    128'h33333333_44444444_55555555_66666666;
  localparam logic [LW-1:0] L4 =
    128'hCAFEF00D_11112222_33334444_55556666;
  localparam logic [LW-1:0] JK = {LW{1'b1}};
  localparam logic [LW-1:0] A5 = {16{8'hA5}};

  typedef struct {
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic [LW-1:0] dwd;
    logic          mr;
    logic [LW-1:0] mrd;
    logic          e_mreq;
    logic          e_mwe;
    logic [AW-1:0] e_maddr;
    logic [LW-1:0] e_mwd;
    logic          e_ird;
    logic          e_drd;
    logic          e_busy;
    logic [LW-1:0] e_irdata;
    logic [LW-1:0] e_drdata;
  } vec_t;

  int passed = 0;
  int total  = 0;

  function automatic vec_t mkv(
    input logic ir, input logic [AW-1:0] ia,
    input logic dr, input logic dw,
    input logic [AW-1:0] da, input logic [LW-1:0] dwd,
    input logic mr, input logic [LW-1:0] mrd,
    input logic emq, input logic emw,
    input logic [AW-1:0] ema, input logic [LW-1:0] emd,
    input logic eir, input logic edr, input logic eb,
    input logic [LW-1:0] eid, input logic [LW-1:0] edd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
    v.da = da; v.dwd = dwd; v.mr = mr; v.mrd = mrd;
    v.e_mreq = emq; v.e_mwe = emw; v.e_maddr = ema;
    v.e_mwd = emd; v.e_ird = eir; v.e_drd = edr;
    v.e_busy = eb; v.e_irdata = eid; v.e_drdata = edd;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    else
      passed++;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    ic_req = 0; ic_addr = '0;
    dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  vec_t vt[14];
  logic [AW-1:0] gaddr[3];
  int   ng;
  int   nbusy;
  logic prev_req;
  logic seen;
  logic err_early;

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_state",
          {mem_req, mem_we, mem_addr, mem_wdata, ic_ready,
           dc_ready, ic_rdata, dc_rdata, busy, timeout_err},
          '0);
    reset = 1'b0;

    // single I read, stray mem_ready, D write, fast D read
    vt[0]  = mkv(1,32'h40,0,0,0,Z,0,Z,   1,0,32'h40,Z,0,0,1,Z,Z);
    vt[1]  = vt[0];
    vt[2]  = vt[0];
    vt[3]  = vt[0];
    vt[4]  = mkv(1,32'h40,0,0,0,Z,1,L1,  0,0,32'h40,Z,1,0,1,L1,Z);
    vt[5]  = mkv(1,32'h40,0,0,0,Z,0,Z,   0,0,32'h40,Z,0,0,0,L1,Z);
    vt[6]  = mkv(0,32'h40,0,0,0,Z,1,JK,  0,0,32'h40,Z,0,0,0,L1,Z);
    vt[7]  = mkv(0,0,1,1,32'h100,A5,0,Z, 1,1,32'h100,A5,0,0,1,L1,Z);
    vt[8]  = mkv(0,0,1,1,32'h100,A5,1,JK,0,0,32'h100,Z,0,1,1,L1,Z);
    vt[9]  = mkv(0,0,1,1,32'h100,A5,0,Z, 0,0,32'h100,Z,0,0,0,L1,Z);
    vt[10] = mkv(0,0,0,0,0,Z,0,Z,        0,0,32'h100,Z,0,0,0,L1,Z);
    vt[11] = mkv(0,0,1,0,32'h200,A5,0,Z, 1,0,32'h200,Z,0,0,1,L1,Z);
    vt[12] = mkv(0,0,1,0,32'h200,A5,1,L2,0,0,32'h200,Z,0,1,1,L1,L2);
    vt[13] = mkv(0,0,1,0,32'h200,A5,0,Z, 0,0,32'h200,Z,0,0,0,L1,L2);

    for (int i = 0; i < 14; i++) begin
      ic_req = vt[i].ir; ic_addr = vt[i].ia;
      dc_req = vt[i].dr; dc_we = vt[i].dw;
      dc_addr = vt[i].da; dc_wdata = vt[i].dwd;
      mem_ready = vt[i].mr; mem_rdata = vt[i].mrd;
      tick();
      check($sformatf("vec%0d", i),
            {mem_req, mem_we, mem_addr,
             (vt[i].e_mwe ? mem_wdata : Z),
             ic_ready, dc_ready, busy, ic_rdata, dc_rdata},
            {vt[i].e_mreq, vt[i].e_mwe, vt[i].e_maddr,
             (vt[i].e_mwe ? vt[i].e_mwd : Z),
             vt[i].e_ird, vt[i].e_drd, vt[i].e_busy,
             vt[i].e_irdata, vt[i].e_drdata});
    end

    // contention from reset: D, I, D
    do_reset();
    ic_req = 1; ic_addr = 32'h1000;
    dc_req = 1; dc_we = 0; dc_addr = 32'h2000;
    ng = 0;
    prev_req = 0;
    for (int c = 0; c < 40 && ng < 3; c++) begin
      tick();
      mem_ready = mem_req;
      mem_rdata = LW'(c);
      if (mem_req && !prev_req) begin
        gaddr[ng] = mem_addr;
        ng++;
      end
      prev_req = mem_req;
    end
    check("rr_grants", 32'(ng), 32'd3);
    check("rr_first_d", gaddr[0], 32'h2000);
    check("rr_second_i", gaddr[1], 32'h1000);
    check("rr_third_d", gaddr[2], 32'h2000);

    // late I arrival while BUSY_D
    do_reset();
    dc_req = 1; dc_we = 0; dc_addr = 32'h300;
    tick();
    ic_req = 1; ic_addr = 32'h400;
    tick();
    check("late_wait", {mem_req, mem_addr}, {1'b1, 32'h300});
    mem_ready = 1; mem_rdata = L3;
    tick();
    mem_ready = 0;
    check("late_resp_d",
          {mem_req, dc_ready, ic_ready, mem_addr},
          {1'b0, 1'b1, 1'b0, 32'h300});
    check("late_d_rdata", dc_rdata, L3);
    tick();
    dc_req = 0;
    check("late_idle", {busy, mem_req, mem_addr},
          {1'b0, 1'b0, 32'h300});
    tick();
    check("late_grant_i", {mem_req, mem_we, mem_addr},
          {1'b1, 1'b0, 32'h400});

    // watchdog: memory never answers an I read
    do_reset();
    ic_req = 1; ic_addr = 32'h500;
    mem_rdata = L4;
    nbusy = 0;
    seen = 0;
    err_early = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ic_ready) begin
        seen = 1;
        break;
      end
      if (mem_req) nbusy++;
      if (timeout_err) err_early = 1;
    end
    check("wd_ready_seen", 1'(seen), 1'b1);
    check("wd_busy_cycles", 32'(nbusy), 32'd8);
    check("wd_not_early", 1'(err_early), 1'b0);
    check("wd_err_set", timeout_err, 1'b1);
    check("wd_rdata_kept", ic_rdata, Z);
    tick();
    ic_req = 0;
    dc_req = 1; dc_we = 0; dc_addr = 32'h600;
    tick();
    mem_ready = 1; mem_rdata = L2;
    tick();
    mem_ready = 0;
    check("wd_after_d",
          {dc_ready, dc_rdata, timeout_err},
          {1'b1, L2, 1'b1});

    // async reset in the middle of BUSY_D
    tick();
    dc_addr = 32'h700;
    tick();
    check("ar_busy", {mem_req, busy, mem_addr},
          {1'b1, 1'b1, 32'h700});
    #2 reset = 1'b1;
    #1;
    check("ar_cleared",
          {mem_req, busy, ic_ready, dc_ready,
           mem_addr, timeout_err},
          '0);
    dc_req = 0;
    ic_req = 1; ic_addr = 32'h800;
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    check("ar_new_grant", {mem_req, mem_we, mem_addr},
          {1'b1, 1'b0, 32'h800});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
